resize_ctrl: RTL and testbench
==============================

Name: resize_ctrl

Overview:
- Frame sequencer for the 2x2 binary downscaler, which has a 194-bit line buffer, a 2x2 window and a registered majority-OR output, Dout = 1 iff at least 2 of 4 window bits are 1.
- Accepts a raster-order 1-bit pixel stream with a valid/ready handshake and drives the downscaler's Din_Valid, Din and Cal_Valid.
- Appends flush pixels so the final row pair is computed.
- Generates out_valid/out_last aligned with Dout, plus frame status.

Parameters:
- IMG_W, 64, pixels per line; must equal the downscaler line-buffer row pitch (taps at 64/128).
- IMG_H, 128, lines per frame; must be even.
- Derived: NPIX = IMG_W*IMG_H; OFS = 2*IMG_W+2 (130); KLAST = NPIX+IMG_W (8256); FLUSH_LEN = IMG_W+1 (65); NOUT = NPIX/4 (2048); counters sized for KLAST (14 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to process one frame; honoured only in IDLE
- s_valid  in  1  upstream pixel valid
- s_data  in  1  upstream pixel
- s_ready  out  1  upstream ready; combinational, high only in STREAM
- din_valid  out  1  to downscaler Din_Valid; combinational
- din  out  1  to downscaler Din; combinational
- cal_valid  out  1  to downscaler Cal_Valid; registered
- out_valid  out  1  Dout holds a valid output pixel this cycle; registered
- out_last  out  1  with out_valid on output pixel NOUT-1
- frame_done  out  1  one-cycle pulse coincident with out_last
- busy  out  1  high from start acceptance until the cycle after out_last

Behaviour:
- Reset values: all registered outputs 0, state IDLE, k=0, out_cnt=0.
- Asynchronous reset mid-frame aborts immediately. No partial outputs after reset release. Next start begins a clean frame.
- States and transitions:
  - IDLE: start -> STREAM, k=0, out_cnt=0, busy=1. s_valid ignored.
  - STREAM: s_ready=1. Transfer when s_valid&s_ready. din_valid=s_valid, din=s_data. k increments per transfer. Transfer with k=NPIX-1 -> FLUSH.
  - FLUSH: s_ready=0, din_valid=1, din=0 every cycle. k increments each cycle. Cycle with k=KLAST -> DRAIN.
  - DRAIN: wait for out_last, then -> IDLE. busy drops the cycle after out_last.
- Window rule (k = index of the pixel pushed this cycle):
  - The edge accepting pixel k loads the downscaler window with the 2x2 block whose top-left raster index is j=k-OFS.
  - cal_valid is set for exactly the cycle following that edge iff k>=OFS, (j/IMG_W) even and (j mod IMG_W) even. Otherwise cal_valid is 0.
  - Consequence: every IMG_W-aligned even/even block is computed once, NOUT pulses per frame.
- Output alignment:
  - out_valid = cal_valid delayed 1 cycle (Dout registers on the edge ending the cal_valid cycle).
  - out_cnt increments per out_valid. out_last/frame_done when out_cnt=NOUT-1.
- Upstream stalls (s_valid low): din_valid low, k holds, cal_valid low next cycle, window frozen. Output order is unaffected, only timing.
- Stale line-buffer content from the previous frame's flush never reaches a cal_valid window (k restarts at 0 and j>=0 is required).
- Latency:
  - First output: out_valid 2 cycles after the edge accepting k=OFS.
  - Last output: 2 cycles after the edge with k=KLAST.
  - Minimum frame time with continuous s_valid: NPIX+FLUSH_LEN+3 cycles from start.
- start while busy is ignored. No second frame is queued.
- The next frame may start the cycle after frame_done.

Test Plan:
- All-zero frame, continuous s_valid -> exactly 2048 out_valid, Dout=0 throughout, out_last/frame_done on the 2048th, busy low 1 cycle later, s_ready low for 65 flush cycles.
- Frame with pixels (0,0),(0,1)=1, rest 0 -> first output Dout=1, remaining 2047 outputs 0. Pixel (0,0) alone=1 -> all 2048 outputs 0.
- Last block pixels (126,62),(127,63)=1 -> only output 2047 (out_last) Dout=1. Proves flush and KLAST=8256.
- Random s_valid gaps (~50% duty) on a random frame -> Dout sequence identical to the no-gap run, 2048 cal_valid pulses, none during stall-induced frozen windows.
- Back-to-back frames, all-ones then all-zeros -> frame 2 outputs all 0. start pulsed during frame 1 is ignored (exactly two frame_done pulses).
- rst_n asserted at k=4000 -> all outputs 0 immediately, no out_valid after release. A new start produces a correct full 2048-output frame.

Source files
------------

// File: rtl/resize_ctrl_if.sv
// Handshake bundle between the frame source/sink and resize_ctrl.
// slave = controller side, master = upstream source and downstream observer.
interface resize_ctrl_if;
  logic start;
  logic s_valid;
  logic s_data;
  logic s_ready;
  logic din_valid;
  logic din;
  logic cal_valid;
  logic out_valid;
  logic out_last;
  logic frame_done;
  logic busy;

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, din_valid, din, cal_valid, out_valid, out_last, frame_done, busy
  );

  modport master (
    output start, s_valid, s_data,
    input  s_ready, din_valid, din, cal_valid, out_valid, out_last, frame_done, busy
  );
endinterface

// File: rtl/resize_ctrl.sv
// Frame sequencer for the 2x2 majority downscaler; pixels pass straight through (0 cycles), Dout valid 2 cycles after a push.
// Backpressure: s_ready high only while streaming; s_valid gaps freeze k and the window, only output timing changes.
module resize_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  resize_ctrl_if.slave  io
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int OFS   = 2 * IMG_W + 2;
  localparam int KLAST = NPIX + IMG_W;
  localparam int NOUT  = NPIX / 4;
  localparam int KW    = $clog2(KLAST + 1);
  localparam int OW    = $clog2(NOUT);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [OW-1:0]   r_out_cnt;
  logic            r_cal_valid;
  logic            r_out_valid;
  logic            w_s_ready;
  logic            w_din_valid;
  logic            w_din;
  logic            w_start_acc;
  logic            w_last;
  logic            w_cal_nxt;
  logic [KW-1:0]   w_j;
  logic [KW-1:0]   w_row;
  logic [KW-1:0]   w_col;

  assign w_start_acc = (r_state == S_IDLE) && io.start;
  assign w_last      = r_out_valid && (r_out_cnt == OW'(NOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_din_valid = 1'b0;
    w_din       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io.start) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_s_ready   = 1'b1;
        w_din_valid = io.s_valid;
        w_din       = io.s_data;
        if (io.s_valid && (r_k == KW'(NPIX - 1))) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // zero pixels push the last row pair through the line buffer
        w_din_valid = 1'b1;
        if (r_k == KW'(KLAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // window loaded by push k has top-left pixel j = k - OFS; compute only even-row/even-col blocks
  assign w_j       = r_k - KW'(OFS);
  assign w_row     = w_j / KW'(IMG_W);
  assign w_col     = w_j % KW'(IMG_W);
  assign w_cal_nxt = w_din_valid && (r_k >= KW'(OFS)) && !w_row[0] && !w_col[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_out_cnt   <= '0;
      r_cal_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_cal_valid <= w_cal_nxt;
      r_out_valid <= r_cal_valid;
      if (w_start_acc) begin
        r_k       <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_din_valid) r_k <= r_k + KW'(1);
        if (r_out_valid) r_out_cnt <= r_out_cnt + OW'(1);
      end
    end
  end

  assign io.s_ready    = w_s_ready;
  assign io.din_valid  = w_din_valid;
  assign io.din        = w_din;
  assign io.cal_valid  = r_cal_valid;
  assign io.out_valid  = r_out_valid;
  assign io.out_last   = w_last;
  assign io.frame_done = w_last;
  assign io.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_resize_ctrl.sv
// Randomized bench for resize_ctrl with a behavioural 2x2 majority downscaler and a per-frame
// block-majority reference computed directly from the image.
module tb_resize_ctrl;
  localparam int W         = 64;
  localparam int H         = 128;
  localparam int NPIX      = W * H;
  localparam int NOUT      = NPIX / 4;
  localparam int FLUSH_LEN = W + 1;

  logic clk;
  logic rst_n;

  resize_ctrl_if bus();

  resize_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downscaler: line buffer with taps at 64/65/129/130 behind the newest pixel, registered majority
  bit [193:0] sr;
  bit [3:0]   win;
  bit         dout;

  always @(posedge clk) begin
    if (bus.din_valid === 1'b1) begin
      sr  <= {sr[192:0], bus.din === 1'b1};
      win <= {sr[129], sr[128], sr[65], sr[64]};
    end
    if (bus.cal_valid === 1'b1) dout <= ($countones(win) >= 2);
  end

  bit img   [NPIX];
  bit rimg  [NPIX];
  bit exp_d [NOUT];

  int n_checks;
  int n_pass;
  int frames_done;
  int idx;
  int cal_cnt;
  int flush_cnt;
  bit prev_dv;
  bit chk_busy_drop;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic compute_exp();
    for (int b = 0; b < NOUT; b++) begin
      int r;
      int c;
      int s;
      r = 2 * (b / (W / 2));
      c = 2 * (b % (W / 2));
      s = int'(img[r*W+c]) + int'(img[r*W+c+1]) + int'(img[(r+1)*W+c]) + int'(img[(r+1)*W+c+1]);
      exp_d[b] = (s >= 2);
    end
  endtask

  // 0 zeros, 1 ones, 2 first pair, 3 corner + last block diagonal, 4 stored random image
  task automatic set_img(input int mode);
    for (int i = 0; i < NPIX; i++) img[i] = (mode == 1) ? 1'b1 : (mode == 4) ? rimg[i] : 1'b0;
    if (mode == 2) begin
      img[0] = 1'b1;
      img[1] = 1'b1;
    end
    if (mode == 3) begin
      img[0]           = 1'b1;
      img[126*W + 62]  = 1'b1;
      img[127*W + 63]  = 1'b1;
    end
    compute_exp();
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_s_ready"},    int'(bus.s_ready),    0);
    check_val({tag, "_din_valid"},  int'(bus.din_valid),  0);
    check_val({tag, "_cal_valid"},  int'(bus.cal_valid),  0);
    check_val({tag, "_out_valid"},  int'(bus.out_valid),  0);
    check_val({tag, "_out_last"},   int'(bus.out_last),   0);
    check_val({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check_val({tag, "_busy"},       int'(bus.busy),       0);
  endtask

  // entered and left just after a rising edge
  task automatic drive_frame(input int gap_pct, input bit start_mid, input int abort_at);
    int n;
    int cyc;
    bit xfer;
    bit mid_sent;
    n = 0;
    cyc = 0;
    mid_sent = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (n < NPIX && cyc < 40000) begin
      bus.s_valid = ($urandom_range(99) >= gap_pct);
      bus.s_data  = img[n];
      bus.start   = start_mid && !mid_sent && (n >= 1000);
      if (bus.start) mid_sent = 1'b1;
      @(negedge clk);
      xfer = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (xfer) n++;
      cyc++;
      if (abort_at > 0 && n >= abort_at) break;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    if (abort_at == 0) check_val("stream_len", n, NPIX);
  endtask

  task automatic wait_frame(input int f0);
    int cyc;
    cyc = 0;
    while (frames_done == f0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("frame_end", frames_done - f0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int f0;
    int ov_cnt;
    n_checks      = 0;
    n_pass        = 0;
    frames_done   = 0;
    idx           = 0;
    cal_cnt       = 0;
    flush_cnt     = 0;
    prev_dv       = 1'b0;
    chk_busy_drop = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_dv       = 1'b0;
          chk_busy_drop = 1'b0;
        end else begin
          if (bus.start && !bus.busy) begin
            idx       = 0;
            cal_cnt   = 0;
            flush_cnt = 0;
          end
          if (chk_busy_drop) begin
            check_val("busy_drop", int'(bus.busy), 0);
            chk_busy_drop = 1'b0;
          end
          if (bus.cal_valid) begin
            cal_cnt++;
            check_val("cal_after_push", int'(prev_dv), 1);
          end
          if (bus.busy && bus.din_valid && !bus.s_ready) flush_cnt++;
          if (bus.out_valid) begin
            if (idx < NOUT) check_val("dout", int'(dout), int'(exp_d[idx]));
            else            check_val("out_count", idx, NOUT - 1);
            check_val("out_last",   int'(bus.out_last),   int'(idx == NOUT - 1));
            check_val("frame_done", int'(bus.frame_done), int'(idx == NOUT - 1));
            if (bus.out_last) begin
              check_val("busy_at_last", int'(bus.busy), 1);
              check_val("cal_pulses", cal_cnt, NOUT);
              check_val("flush_cycles", flush_cnt, FLUSH_LEN);
              frames_done++;
              chk_busy_drop = 1'b1;
            end
            idx++;
          end
          prev_dv = bus.din_valid;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("idle");
    bus.s_valid = 1'b0;

    for (int i = 0; i < NPIX; i++) rimg[i] = ($urandom & 32'd1) != 0;

    // first block pair -> only output 0 is 1
    set_img(2);
    f0 = frames_done;
    drive_frame(0, 1'b0, 0);
    wait_frame(f0);

    // lone top-left pixel stays 0; last block diagonal makes only the final output 1
    set_img(3);
    f0 = frames_done;
    drive_frame(0, 1'b0, 0);
    wait_frame(f0);

    // random image with roughly half the cycles stalled
    set_img(4);
    f0 = frames_done;
    drive_frame(50, 1'b0, 0);
    wait_frame(f0);

    // back-to-back all-ones then all-zeros, with an ignored start mid-frame
    f0 = frames_done;
    set_img(1);
    drive_frame(0, 1'b1, 0);
    wait_frame(f0);
    set_img(0);
    drive_frame(0, 1'b0, 0);
    wait_frame(f0 + 1);
    repeat (200) @(negedge clk);
    check_val("two_frames", frames_done - f0, 2);
    @(posedge clk); #1;

    // reset in the middle of a frame, then a clean full frame
    set_img(4);
    f0 = frames_done;
    drive_frame(0, 1'b0, 4000);
    rst_n       = 1'b0;
    bus.s_valid = 1'b1;
    #1;
    check_quiet("abort");
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ov_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check_val("post_rst_out_valid", ov_cnt, 0);
    check_val("post_rst_frames", frames_done - f0, 0);
    @(posedge clk); #1;
    f0 = frames_done;
    drive_frame(0, 1'b0, 0);
    wait_frame(f0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
